// File: rtl/lpc_cycle_decoder_pkg.sv
// Shared types and LPC protocol constants for the LPC cycle decoder.
// START, CYCTYPE and SYNC nibble encodings live here so the decoder and its users agree on them.
package lpc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CYCTYPE,
        ST_ADDR,
        ST_WDATA,
        ST_TAR1,
        ST_SYNC,
        ST_RDATA,
        ST_TAR2
    } state_t;

    localparam logic [1:0] CYC_IO  = 2'b00;
    localparam logic [1:0] CYC_MEM = 2'b01;
    localparam int         DIR_BIT = 1;

    localparam logic [3:0] SYNC_READY   = 4'b0000;
    localparam logic [3:0] SYNC_SWAIT   = 4'b0101;
    localparam logic [3:0] SYNC_LWAIT   = 4'b0110;
    localparam logic [3:0] SYNC_ERR     = 4'b1010;
    localparam logic [3:0] START_NIBBLE = 4'b0000;

    function automatic logic is_wait_sync(input logic [3:0] nib);
        return (nib == SYNC_SWAIT) || (nib == SYNC_LWAIT);
    endfunction

endpackage

// File: rtl/lpc_cycle_decoder_if.sv
// LPC pin bundle plus the decoded-record outputs of the cycle decoder.
// The master side drives LAD/LFRAME#; the slave side is the decoder.
interface lpc_cycle_decoder_if;

    logic [3:0]  lpc_ad;
    logic        lpc_frame;
    logic [3:0]  out_cyctype_dir;
    logic [31:0] out_addr;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sync_err;
    logic        out_abort;

    modport master (
        output lpc_ad, lpc_frame,
        input  out_cyctype_dir, out_addr, out_data, out_valid, out_sync_err, out_abort
    );

    modport slave (
        input  lpc_ad, lpc_frame,
        output out_cyctype_dir, out_addr, out_data, out_valid, out_sync_err, out_abort
    );

endinterface

// File: rtl/lpc_cycle_decoder.sv
// Passive LPC I/O and memory cycle decoder: follows each bus cycle nibble by nibble and
// emits one record per completed cycle, or an abort pulse when the cycle is abandoned.
module lpc_cycle_decoder
    import lpc_pkg::*;
#(
    parameter bit          MEM_EN       = 1'b1,
    parameter int unsigned SYNC_TIMEOUT = 32,
    parameter bit          FILTER_EN    = 1'b0,
    parameter logic [31:0] FILTER_BASE  = 32'h0,
    parameter logic [31:0] FILTER_MASK  = 32'h0
) (
    input logic                lpc_clock,
    input logic                lpc_reset,
    lpc_cycle_decoder_if.slave bus
);

    localparam logic [8:0] TIMEOUT_W = 9'(SYNC_TIMEOUT);

    state_t      state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic [7:0]  wait_cnt, wait_nx;
    logic [3:0]  cyc, cyc_nx;
    logic [31:0] addr, addr_nx;
    logic [7:0]  data, data_nx;
    logic        err, err_nx;

    logic        rec_done;
    logic [7:0]  rec_data;
    logic        rec_err;
    logic        abort_nx;

    logic [3:0]  rep_cyc;
    logic [31:0] rep_addr;
    logic [7:0]  rep_data;
    logic        rep_err;
    logic        valid_q;
    logic        abort_q;

    logic [8:0]  wait_inc;
    logic [2:0]  last_addr;
    logic        match;

    assign wait_inc  = {1'b0, wait_cnt} + 9'd1;
    assign last_addr = (cyc[3:2] == CYC_MEM) ? 3'd7 : 3'd3;
    assign match     = (FILTER_EN == 1'b0) ||
                       ((addr & FILTER_MASK) == (FILTER_BASE & FILTER_MASK));

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_nx = state;
        cnt_nx   = cnt;
        wait_nx  = wait_cnt;
        cyc_nx   = cyc;
        addr_nx  = addr;
        data_nx  = data;
        err_nx   = err;
        rec_done = 1'b0;
        rec_data = data;
        rec_err  = err;
        abort_nx = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!bus.lpc_frame && bus.lpc_ad == START_NIBBLE) state_nx = ST_CYCTYPE;
            end
            ST_CYCTYPE: begin
                if (!bus.lpc_frame) begin
                    if (bus.lpc_ad != START_NIBBLE) state_nx = ST_IDLE;
                end else begin
                    cyc_nx  = bus.lpc_ad;
                    addr_nx = '0;
                    data_nx = '0;
                    err_nx  = 1'b0;
                    cnt_nx  = '0;
                    if (bus.lpc_ad[3:2] == CYC_IO ||
                        (bus.lpc_ad[3:2] == CYC_MEM && MEM_EN == 1'b1)) begin
                        state_nx = ST_ADDR;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_ADDR: begin
                addr_nx = {addr[27:0], bus.lpc_ad};
                cnt_nx  = cnt + 3'd1;
                if (cnt == last_addr) begin
                    cnt_nx   = '0;
                    state_nx = cyc[DIR_BIT] ? ST_WDATA : ST_TAR1;
                end
            end
            ST_WDATA: begin
                if (cnt == 3'd0) begin
                    data_nx[3:0] = bus.lpc_ad;
                    cnt_nx       = 3'd1;
                end else begin
                    data_nx[7:4] = bus.lpc_ad;
                    cnt_nx       = '0;
                    state_nx     = ST_TAR1;
                end
            end
            ST_TAR1: begin
                if (cnt == 3'd1) begin
                    cnt_nx   = '0;
                    wait_nx  = '0;
                    state_nx = ST_SYNC;
                end else begin
                    cnt_nx = 3'd1;
                end
            end
            ST_SYNC: begin
                if (bus.lpc_ad == SYNC_READY || bus.lpc_ad == SYNC_ERR) begin
                    err_nx = (bus.lpc_ad == SYNC_ERR);
                    cnt_nx = '0;
                    if (cyc[DIR_BIT]) begin
                        rec_done = 1'b1;
                        rec_err  = (bus.lpc_ad == SYNC_ERR);
                        state_nx = ST_TAR2;
                    end else begin
                        state_nx = ST_RDATA;
                    end
                end else if (is_wait_sync(bus.lpc_ad)) begin
                    if (wait_inc >= TIMEOUT_W) begin
                        abort_nx = 1'b1;
                        state_nx = ST_IDLE;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_nx = wait_cnt + 8'd1;
                    end
                end else begin
                    abort_nx = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_RDATA: begin
                if (cnt == 3'd0) begin
                    data_nx[3:0] = bus.lpc_ad;
                    cnt_nx       = 3'd1;
                end else begin
                    rec_done = 1'b1;
                    rec_data = {bus.lpc_ad, data[3:0]};
                    data_nx  = {bus.lpc_ad, data[3:0]};
                    cnt_nx   = '0;
                    state_nx = ST_TAR2;
                end
            end
            ST_TAR2: begin
                if (cnt == 3'd1) begin
                    cnt_nx   = '0;
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = 3'd1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        // LFRAME# low mid-cycle overrides everything; in TAR2 the record is already out, so no pulse.
        if (!bus.lpc_frame && state != ST_IDLE && state != ST_CYCTYPE) begin
            state_nx = (bus.lpc_ad == START_NIBBLE) ? ST_CYCTYPE : ST_IDLE;
            cnt_nx   = '0;
            rec_done = 1'b0;
            abort_nx = (state != ST_TAR2);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            wait_cnt <= '0;
            cyc      <= '0;
            addr     <= '0;
            data     <= '0;
            err      <= 1'b0;
            rep_cyc  <= '0;
            rep_addr <= '0;
            rep_data <= '0;
            rep_err  <= 1'b0;
            valid_q  <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            wait_cnt <= wait_nx;
            cyc      <= cyc_nx;
            addr     <= addr_nx;
            data     <= data_nx;
            err      <= err_nx;
            valid_q  <= rec_done && match;
            abort_q  <= abort_nx;
            if (rec_done && match) begin
                rep_cyc  <= cyc;
                rep_addr <= addr;
                rep_data <= rec_data;
                rep_err  <= rec_err;
            end
        end
    end

    assign bus.out_cyctype_dir = rep_cyc;
    assign bus.out_addr        = rep_addr;
    assign bus.out_data        = rep_data;
    assign bus.out_sync_err    = rep_err;
    assign bus.out_valid       = valid_q;
    assign bus.out_abort       = abort_q;

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// Scoreboard bench: two decoders with different parameter sets watch the same LPC pins;
// a transaction-level model predicts each one's records and aborts.
module tb_lpc_cycle_decoder;

    typedef struct {
        bit          is_abort;
        int          edge_n;
        logic [31:0] addr;
        logic [7:0]  data;
        logic [3:0]  cyc;
        logic        err;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame = 1'b1;
    logic [3:0] ad    = 4'hF;

    int total   = 0;
    int bad     = 0;
    int cyc_cnt = 0;

    exp_t        q[2][$];
    logic [31:0] held_addr[2];
    logic [7:0]  held_data[2];
    logic [3:0]  held_cyc[2];
    logic        held_err[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    lpc_cycle_decoder_if if_a ();
    lpc_cycle_decoder_if if_b ();

    assign if_a.lpc_frame = frame;
    assign if_a.lpc_ad    = ad;
    assign if_b.lpc_frame = frame;
    assign if_b.lpc_ad    = ad;

    lpc_cycle_decoder #(
        .MEM_EN(1'b1), .SYNC_TIMEOUT(32), .FILTER_EN(1'b0),
        .FILTER_BASE(32'h0), .FILTER_MASK(32'h0)
    ) dut_a (
        .lpc_clock(clk), .lpc_reset(rst_n), .bus(if_a.slave)
    );

    lpc_cycle_decoder #(
        .MEM_EN(1'b0), .SYNC_TIMEOUT(4), .FILTER_EN(1'b1),
        .FILTER_BASE(32'h80), .FILTER_MASK(32'hFFF0)
    ) dut_b (
        .lpc_clock(clk), .lpc_reset(rst_n), .bus(if_b.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic mon(input int id, input logic v, input logic ab, input logic se,
                       input logic [3:0] ct, input logic [31:0] a32, input logic [7:0] dt);
        exp_t  e;
        string t;
        t = (id == 0) ? "a" : "b";
        check({t, "_valid_and_abort"}, {31'b0, v & ab}, 32'd0);
        if (v || ab) begin
            if (q[id].size() == 0) begin
                check({t, "_unexpected_pulse"}, {30'b0, v, ab}, 32'd0);
            end else begin
                e = q[id].pop_front();
                check({t, "_pulse_kind"}, {30'b0, v, ab}, e.is_abort ? 32'd1 : 32'd2);
                check({t, "_pulse_edge"}, cyc_cnt, e.edge_n);
                if (!e.is_abort) begin
                    held_addr[id] = e.addr;
                    held_data[id] = e.data;
                    held_cyc[id]  = e.cyc;
                    held_err[id]  = e.err;
                end
            end
        end
        check({t, "_addr"}, a32, held_addr[id]);
        check({t, "_data"}, {24'b0, dt}, {24'b0, held_data[id]});
        check({t, "_cyctype_dir"}, {28'b0, ct}, {28'b0, held_cyc[id]});
        check({t, "_sync_err"}, {31'b0, se}, {31'b0, held_err[id]});
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, if_a.out_valid, if_a.out_abort, if_a.out_sync_err,
                if_a.out_cyctype_dir, if_a.out_addr, if_a.out_data);
            mon(1, if_b.out_valid, if_b.out_abort, if_b.out_sync_err,
                if_b.out_cyctype_dir, if_b.out_addr, if_b.out_data);
        end
    end

    task automatic drive(input logic [4:0] n);
        @(negedge clk);
        frame = n[4];
        ad    = n[3:0];
    endtask

    // endk: 0 ready, 1 error SYNC, 2 illegal SYNC.  abort_at: -1 none, -2 random, else nibble index.
    task automatic run_txn(input bit mem, input bit wr, input logic [31:0] a_in, input logic [7:0] d,
                           input int nwait, input logic [3:0] wcode, input int endk,
                           input int abort_at_in, input logic [3:0] abort_ad, input bit skip_start,
                           input int tar2_len, input int idles);
        logic [4:0]  seq[$];
        logic [31:0] a;
        logic [3:0]  ct;
        logic [3:0]  endnib;
        int          s_idx, abort_at, idx, to;
        bit          has[2];
        int          ev[2];
        exp_t        ex[2];
        bit          mem_en, filt;

        a  = mem ? a_in : {16'h0, a_in[15:0]};
        ct = {1'b0, mem, wr, 1'b0};
        if (!skip_start) seq.push_back({1'b0, 4'h0});
        seq.push_back({1'b1, ct});
        for (int i = (mem ? 7 : 3); i >= 0; i--) seq.push_back({1'b1, a[4*i +: 4]});
        if (wr) begin
            seq.push_back({1'b1, d[3:0]});
            seq.push_back({1'b1, d[7:4]});
        end
        seq.push_back(5'h1F);
        seq.push_back(5'h1F);
        s_idx = seq.size();
        for (int i = 0; i < nwait; i++) seq.push_back({1'b1, wcode});
        endnib = (endk == 0) ? 4'h0 : (endk == 1) ? 4'hA : 4'h9;
        seq.push_back({1'b1, endnib});
        if (!wr) begin
            seq.push_back({1'b1, d[3:0]});
            seq.push_back({1'b1, d[7:4]});
        end
        for (int i = 0; i < tar2_len; i++) seq.push_back(5'h1F);

        abort_at = abort_at_in;
        if (abort_at == -2) abort_at = ($urandom % 7 == 0) ? $urandom_range(seq.size() - 1, 2) : -1;

        for (int id = 0; id < 2; id++) begin
            mem_en = (id == 0);
            to     = (id == 0) ? 32 : 4;
            filt   = (id == 1);
            has[id] = 1'b0;
            ev[id]  = -1;
            ex[id]  = '{is_abort: 1'b1, edge_n: 0, addr: a, data: d, cyc: ct, err: (endk == 1)};
            if (!(mem && !mem_en)) begin
                if (nwait >= to) begin
                    idx = s_idx + to - 1;
                    has[id] = 1'b1;
                end else if (endk == 2) begin
                    idx = s_idx + nwait;
                    has[id] = 1'b1;
                end else begin
                    idx = s_idx + nwait + (wr ? 0 : 2);
                    ex[id].is_abort = 1'b0;
                    has[id] = !filt || ((a & 32'hFFF0) == 32'h80);
                end
                if (abort_at >= 0 && abort_at <= idx) begin
                    has[id] = 1'b1;
                    ex[id].is_abort = 1'b1;
                    idx = abort_at;
                end
                ev[id] = idx;
            end
        end

        if (abort_at >= 0) begin
            seq[abort_at] = {1'b0, abort_ad};
            while (seq.size() > abort_at + 1) void'(seq.pop_back());
        end
        for (int i = 0; i < idles; i++) seq.push_back(5'h1F);

        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i]);
            for (int id = 0; id < 2; id++) begin
                if (has[id] && ev[id] == i) begin
                    ex[id].edge_n = cyc_cnt + 1;
                    q[id].push_back(ex[id]);
                end
            end
        end
    endtask

    initial begin
        for (int id = 0; id < 2; id++) begin
            held_addr[id] = '0;
            held_data[id] = '0;
            held_cyc[id]  = '0;
            held_err[id]  = 1'b0;
        end
        #2;
        check("reset_a_valid", {31'b0, if_a.out_valid}, 32'd0);
        check("reset_a_abort", {31'b0, if_a.out_abort}, 32'd0);
        check("reset_a_addr", if_a.out_addr, 32'd0);
        check("reset_b_valid", {31'b0, if_b.out_valid}, 32'd0);
        check("reset_b_data", {24'b0, if_b.out_data}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios
        run_txn(1'b0, 1'b1, 32'h0080, 8'h5A, 0, 4'h5, 0, -1, 4'hF, 1'b0, 2, 2);
        run_txn(1'b0, 1'b0, 32'h002E, 8'hC3, 3, 4'h5, 0, -1, 4'hF, 1'b0, 2, 2);
        run_txn(1'b1, 1'b0, 32'hFFFFFFF0, 8'h21, 0, 4'h5, 1, -1, 4'hF, 1'b0, 2, 2);
        run_txn(1'b0, 1'b1, 32'h0081, 8'h11, 0, 4'h5, 0, 3, 4'hF, 1'b0, 2, 1);
        run_txn(1'b0, 1'b1, 32'h0082, 8'h22, 0, 4'h5, 0, -1, 4'hF, 1'b0, 2, 2);
        run_txn(1'b0, 1'b1, 32'h0083, 8'h33, 0, 4'h5, 0, 4, 4'h0, 1'b0, 2, 0);
        run_txn(1'b0, 1'b1, 32'h0085, 8'h44, 1, 4'h6, 0, -1, 4'hF, 1'b1, 2, 2);
        run_txn(1'b0, 1'b1, 32'h0084, 8'h66, 6, 4'h6, 0, -1, 4'hF, 1'b0, 2, 2);
        run_txn(1'b0, 1'b1, 32'h0084, 8'h77, 0, 4'h5, 1, -1, 4'hF, 1'b0, 2, 2);
        run_txn(1'b0, 1'b1, 32'h0060, 8'h99, 0, 4'h5, 0, -1, 4'hF, 1'b0, 1, 0);
        run_txn(1'b0, 1'b0, 32'h008F, 8'hE1, 2, 4'h5, 0, -1, 4'hF, 1'b0, 0, 2);

        // Reset asserted mid-SYNC: outputs must clear at once without any pulse
        drive({1'b0, 4'h0});
        drive({1'b1, 4'h2});
        drive(5'h10); drive(5'h10); drive(5'h18); drive(5'h14);
        drive(5'h1A); drive(5'h1B); drive(5'h1F); drive(5'h1F);
        drive(5'h15); drive(5'h15);
        #7 rst_n = 1'b0;
        #1;
        check("rst_mid_a_addr", if_a.out_addr, 32'd0);
        check("rst_mid_a_data", {24'b0, if_a.out_data}, 32'd0);
        check("rst_mid_a_cyc", {28'b0, if_a.out_cyctype_dir}, 32'd0);
        check("rst_mid_a_err", {31'b0, if_a.out_sync_err}, 32'd0);
        check("rst_mid_b_addr", if_b.out_addr, 32'd0);
        check("rst_mid_b_data", {24'b0, if_b.out_data}, 32'd0);
        check("rst_mid_b_pulses", {30'b0, if_b.out_valid, if_b.out_abort}, 32'd0);
        for (int id = 0; id < 2; id++) begin
            held_addr[id] = '0;
            held_data[id] = '0;
            held_cyc[id]  = '0;
            held_err[id]  = 1'b0;
        end
        frame = 1'b1;
        ad    = 4'hF;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            bit          mem, wr;
            logic [31:0] a;
            int          nwait, endk, r;
            mem = ($urandom % 3 == 0);
            wr  = $urandom % 2;
            if (mem) a = ($urandom % 3 == 0) ? {$urandom_range(16'hFFFF, 0) & 32'hFFFF, 12'h008, 4'($urandom)} << 0 : $urandom;
            else     a = ($urandom % 3 == 0) ? {24'h0, 4'h8, 4'($urandom)} : {16'h0, 16'($urandom)};
            if (mem && a[15:4] != 12'h008 && $urandom % 2 == 0) a = {a[31:16], 12'h008, a[3:0]};
            nwait = ($urandom % 12 == 0) ? $urandom_range(34, 31) : $urandom_range(6, 0);
            r     = $urandom % 10;
            endk  = (r < 7) ? 0 : (r < 9) ? 1 : 2;
            run_txn(mem, wr, a, 8'($urandom), nwait, ($urandom % 2) ? 4'h5 : 4'h6, endk,
                    -2, 4'hF, 1'b0, $urandom_range(2, 0), $urandom_range(2, 0));
        end

        repeat (4) drive(5'h1F);
        check("a_pending_left", q[0].size(), 32'd0);
        check("b_pending_left", q[1].size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
